// File: rtl/booth_arbiter.sv
// Round-robin front end that shares one Booth multiplier datapath between NREQ clients.
// Optional macro BOOTH_ARB_TIMEOUT_EN aborts a WAIT that sees no mul_fin within TIMEOUT cycles.
module booth_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 31
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] opa_i,
  input  logic [NREQ*WIDTH-1:0] opb_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic                  mul_start_o,
  output logic [WIDTH-1:0]      mul_a_o,
  output logic [WIDTH-1:0]      mul_b_o,
  input  logic                  mul_fin_i,
  input  logic [2*WIDTH-1:0]    mul_p_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [IDW-1:0]        res_id_o,
  output logic [2*WIDTH-1:0]    res_p_o,
  output logic                  res_err_o
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESULT} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       rr_q, rr_d, res_id_q, res_id_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic                 mul_start_q, mul_start_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic                 res_valid_q, res_valid_d;
  logic [2*WIDTH-1:0]   res_p_q, res_p_d;
  logic                 first_q, first_d;
`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 res_err_q, res_err_d;
`endif

  // Round-robin search: scan offsets 0..NREQ-1 from rr_q, first set request wins.
  logic [IDW:0]   sum;
  logic [IDW-1:0] win;
  logic           found;
  logic [WIDTH-1:0] sel_a, sel_b;

  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int j = 0; j < NREQ; j++) begin
      sum = {1'b0, rr_q} + (IDW+1)'(j);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (!found && req_i[sum[IDW-1:0]]) begin
        found = 1'b1;
        win   = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win) begin
        sel_a = opa_i[i*WIDTH +: WIDTH];
        sel_b = opb_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = '0;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_p_d     = res_p_q;
    first_d     = first_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    res_err_d   = res_err_q;
`endif
    case (state_q)
      IDLE: if (found) begin
        for (int i = 0; i < NREQ; i++) gnt_d[i] = (IDW'(i) == win);
        mul_start_d = 1'b1;
        mul_a_d     = sel_a;
        mul_b_d     = sel_b;
        res_id_d    = win;
        rr_d        = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
        state_d     = START;
      end
      START: begin
        first_d = 1'b1;
`ifdef BOOTH_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        // The first WAIT cycle may still see fin from the previous product.
        first_d = 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
        cnt_d   = cnt_q + 1'b1;
`endif
        if (!first_q && mul_fin_i) begin
          res_p_d     = mul_p_i;
          res_valid_d = 1'b1;
          state_d     = RESULT;
`ifdef BOOTH_ARB_TIMEOUT_EN
          res_err_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_p_d     = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = RESULT;
`endif
        end
      end
      RESULT: if (res_ready_i) begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_p_q     <= '0;
      first_q     <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_p_q     <= res_p_d;
      first_q     <= first_d;
`ifdef BOOTH_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      res_err_q   <= res_err_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign mul_start_o = mul_start_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign res_valid_o = res_valid_q;
  assign res_id_o    = res_id_q;
  assign res_p_o     = res_p_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
  assign res_err_o   = res_err_q;
`else
  assign res_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_booth_arbiter.sv
// Directed bench for booth_arbiter with a small behavioural multiplier (5-cycle latency, level fin).
module tb_booth_arbiter;
  localparam int NREQ = 4, WIDTH = 8, IDW = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*WIDTH-1:0] opa = '0, opb = '0;
  logic [NREQ-1:0] gnt;
  logic mul_start, mul_fin = 1'b0, res_valid, res_ready = 1'b0, res_err;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic [2*WIDTH-1:0] mul_p = '0, res_p, calc = '0;
  logic [IDW-1:0] res_id;

  int checks = 0, failures = 0, n = 0;
  int mode = 0;  // 0 normal, 1 fin stuck low, 2 stale fin held into first WAIT cycle
  int lat = 0;
  logic [15:0] rr_p [4] = '{16'hFFFA, 16'hFFF7, 16'hFFF4, 16'hFFF1};

  booth_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .opa_i(opa), .opb_i(opb),
    .gnt_o(gnt), .mul_start_o(mul_start), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_fin_i(mul_fin), .mul_p_i(mul_p), .res_valid_o(res_valid),
    .res_ready_i(res_ready), .res_id_o(res_id), .res_p_o(res_p), .res_err_o(res_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mul_start) begin
      calc <= $signed(mul_a) * $signed(mul_b);
      lat  <= (mode == 1) ? 0 : 5;
      fin_start();
    end else if (lat > 1) begin
      if (lat == 5) mul_fin <= 1'b0;
      lat <= lat - 1;
    end else if (lat == 1) begin
      lat     <= 0;
      mul_fin <= 1'b1;
      mul_p   <= calc;
    end
  end

  task automatic fin_start();
    if (mode == 2) begin
      mul_fin <= 1'b1;
      mul_p   <= 16'h1234;
    end else begin
      mul_fin <= 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int maxc, output int cnt);
    cnt = 0;
    while (res_valid !== 1'b1 && cnt < maxc) begin tick(); cnt++; end
    chk("valid_seen", {31'd0, res_valid}, 1);
  endtask

  task automatic wait_gnt(input int maxc);
    int c = 0;
    while (gnt === '0 && c < maxc) begin tick(); c++; end
    chk("gnt_seen", {31'd0, gnt !== '0}, 1);
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    opa[i*WIDTH +: WIDTH] = a;
    opb[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_start"}, mul_start, 0);
    chk({tag, "_a"}, mul_a, 0);
    chk({tag, "_b"}, mul_b, 0);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_id"}, res_id, 0);
    chk({tag, "_p"}, res_p, 0);
    chk({tag, "_err"}, res_err, 0);
  endtask

  initial begin
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Single request: 3 * -2
    set_ops(0, 8'h03, 8'hFE);
    req = 4'b0001;
    tick();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_start", mul_start, 1);
    chk("t1_a", mul_a, 8'h03);
    chk("t1_b", mul_b, 8'hFE);
    tick();
    req = '0;
    chk("t1_gnt_pulse", gnt, 0);
    chk("t1_start_pulse", mul_start, 0);
    wait_valid(20, n);
    chk("t1_latency", n, 6);
    chk("t1_id", res_id, 0);
    chk("t1_p", res_p, 16'hFFFA);
    chk("t1_err", res_err, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_hold_valid", res_valid, 1);
      chk("t1_hold_p", res_p, 16'hFFFA);
    end
    consume();
    chk("t1_done", res_valid, 0);

    // Round-robin from a freshly reset pointer
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 2), 8'hFD);
    req = 4'b1111;
    res_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(30);
      chk("rr_gnt", gnt, 32'd1 << (g % 4));
      tick();
      chk("rr_gnt_pulse", gnt, 0);
      wait_valid(20, n);
      chk("rr_id", res_id, g % 4);
      chk("rr_p", res_p, rr_p[g % 4]);
    end
    req = '0;
    tick();
    res_ready = 1'b0;

    // Backpressure: 127 * -128 pending while requester 1 waits
    set_ops(0, 8'h7F, 8'h80);
    req = 4'b0001;
    wait_gnt(5);
    chk("bp_gnt0", gnt, 4'b0001);
    tick();
    req = '0;
    wait_valid(20, n);
    chk("bp_p0", res_p, 16'hC080);
    set_ops(1, 8'h80, 8'h80);
    req = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("bp_valid", res_valid, 1);
      chk("bp_id", res_id, 0);
      chk("bp_p", res_p, 16'hC080);
      chk("bp_gnt", gnt, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_release_valid", res_valid, 0);
    chk("bp_release_gnt", gnt, 0);
    tick();
    chk("bp_gnt1", gnt, 4'b0010);
    req = '0;
    wait_valid(20, n);
    chk("bp_id1", res_id, 1);
    chk("bp_p1", res_p, 16'h4000);
    consume();

    // Stale fin: fin stays high through START and the first WAIT cycle with 16'h1234
    mode = 2;
    set_ops(2, 8'hF6, 8'h0C);
    req = 4'b0100;
    wait_gnt(5);
    chk("st_gnt", gnt, 4'b0100);
    tick();
    req = '0;
    chk("st_valid_w1", res_valid, 0);
    tick();
    chk("st_valid_w2", res_valid, 0);
    wait_valid(20, n);
    chk("st_latency", n, 5);
    chk("st_p", res_p, 16'hFF88);
    mode = 0;
    consume();

    // Fin stuck low on requester 1
    mode = 1;
    req = 4'b0010;
    wait_gnt(5);
    chk("hang_gnt", gnt, 4'b0010);
    tick();
    req = '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
    for (int k = 0; k < 30; k++) tick();
    chk("to_early", res_valid, 0);
    tick();
    chk("to_valid", res_valid, 1);
    chk("to_err", res_err, 1);
    chk("to_p", res_p, 0);
    chk("to_id", res_id, 1);
    consume();
    mode = 0;
    req = 4'b0001;
    wait_gnt(5);
    tick();
    req = '0;
    wait_valid(20, n);
    chk("to_next_err", res_err, 0);
    chk("to_next_p", res_p, 16'hC080);
    consume();
    mode = 1;
    req = 4'b0010;
    wait_gnt(5);
    tick();
    req = '0;
    for (int k = 0; k < 5; k++) tick();
`else
    for (int k = 0; k < 40; k++) tick();
    chk("hang_valid", res_valid, 0);
    chk("hang_err", res_err, 0);
`endif

    // Reset mid-WAIT; pointer returns to 0, so 0101 grants requester 0 not 2
    rst_n = 1'b0;
    tick();
    chk_all_zero("rst_wait");
    mode = 0;
    rst_n = 1'b1;
    set_ops(0, 8'h05, 8'h07);
    req = 4'b0101;
    tick();
    chk("rst_gnt", gnt, 4'b0001);
    chk("rst_start", mul_start, 1);
    tick();
    req = '0;
    wait_valid(20, n);
    chk("rst_id", res_id, 0);
    chk("rst_p", res_p, 16'h0023);
    chk("rst_err", res_err, 0);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
